// File: rtl/s2mm_burst_splitter.sv
`default_nettype none
// ============================================================================
// Module   : s2mm_burst_splitter
// Brief    : Splits one S2MM transfer command into 4 KB-safe AXI4 INCR bursts
//            and gates the beat stream so each burst carries its own tlast.
// Revision : 1.0 - initial release
// ============================================================================
module s2mm_burst_splitter #(
    parameter int DMA_DATA_WIDTH_SRC = 64,
    parameter int DMA_AXI_ADDR_WIDTH = 32,
    parameter int CMD_BEATS_WIDTH    = 24
) (
    input  logic                          m_axi_aclk,
    input  logic                          m_axi_areset,
    input  logic                          cmd_start_i,
    input  logic [DMA_AXI_ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [CMD_BEATS_WIDTH-1:0]    cmd_beats_i,
    output logic                          cmd_busy_o,
    output logic                          cmd_done_o,
    output logic                          write_start_o,
    output logic [DMA_AXI_ADDR_WIDTH-1:0] write_addr_o,
    output logic [7:0]                    write_len_o,
    output logic [2:0]                    write_size_o,
    input  logic                          write_busy_i,
    input  logic [DMA_DATA_WIDTH_SRC-1:0] s_axis_tdata,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    output logic [DMA_DATA_WIDTH_SRC-1:0] m_axis_tdata,
    output logic                          m_axis_tvalid,
    output logic                          m_axis_tlast,
    input  logic                          m_axis_tready
);

    localparam int c_SIZE_LOG = $clog2(DMA_DATA_WIDTH_SRC / 8);
    localparam logic [DMA_AXI_ADDR_WIDTH-1:0] c_ADDR_MASK =
        {DMA_AXI_ADDR_WIDTH{1'b1}} << c_SIZE_LOG;

    localparam logic [2:0] c_ST_IDLE        = 3'd0;
    localparam logic [2:0] c_ST_CALC        = 3'd1;
    localparam logic [2:0] c_ST_ISSUE       = 3'd2;
    localparam logic [2:0] c_ST_WAIT_ACCEPT = 3'd3;
    localparam logic [2:0] c_ST_WAIT_DONE   = 3'd4;

    logic [2:0]                    r_state;
    logic [2:0]                    w_state_next;
    logic [CMD_BEATS_WIDTH-1:0]    r_rem_beats;
    logic [DMA_AXI_ADDR_WIDTH-1:0] r_cur_addr;
    logic [8:0]                    r_burst_beats;
    logic [8:0]                    r_beat_cnt;
    logic                          r_data_en;
    logic                          r_cmd_done;
    logic [DMA_AXI_ADDR_WIDTH-1:0] r_write_addr;
    logic [7:0]                    r_write_len;

    logic [12:0]                   w_to_4k;
    logic [8:0]                    w_cap;
    logic [8:0]                    w_burst;
    logic [CMD_BEATS_WIDTH-1:0]    w_rem_next;
    logic [DMA_AXI_ADDR_WIDTH-1:0] w_addr_next;
    logic                          w_burst_end;
    logic                          w_last;
    logic                          w_fire;

    // Burst size: the smallest of what is left, the AXI4 limit and the room to the next 4 KB page.
    always_comb begin
        w_to_4k     = (13'd4096 - {1'b0, r_cur_addr[11:0]}) >> c_SIZE_LOG;
        w_cap       = (r_rem_beats > CMD_BEATS_WIDTH'(256)) ? 9'd256 : r_rem_beats[8:0];
        w_burst     = (w_to_4k < {4'b0000, w_cap}) ? w_to_4k[8:0] : w_cap;
        w_rem_next  = r_rem_beats - CMD_BEATS_WIDTH'(r_burst_beats);
        w_addr_next = r_cur_addr + (DMA_AXI_ADDR_WIDTH'(r_burst_beats) << c_SIZE_LOG);
        w_burst_end = !write_busy_i && !r_data_en;
        w_last      = r_data_en && (r_beat_cnt == r_burst_beats - 9'd1);
        w_fire      = s_axis_tvalid && m_axis_tready && r_data_en;
    end

    always_ff @(posedge m_axi_aclk) begin
        if (m_axi_areset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (cmd_start_i && (cmd_beats_i != '0)) begin
                    w_state_next = c_ST_CALC;
                end
            end
            c_ST_CALC:  w_state_next = c_ST_ISSUE;
            c_ST_ISSUE: w_state_next = c_ST_WAIT_ACCEPT;
            c_ST_WAIT_ACCEPT: begin
                if (write_busy_i) begin
                    w_state_next = c_ST_WAIT_DONE;
                end
            end
            c_ST_WAIT_DONE: begin
                if (w_burst_end) begin
                    w_state_next = (w_rem_next == '0) ? c_ST_IDLE : c_ST_CALC;
                end
            end
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge m_axi_aclk) begin
        if (m_axi_areset) begin
            r_rem_beats   <= '0;
            r_cur_addr    <= '0;
            r_burst_beats <= '0;
            r_beat_cnt    <= '0;
            r_data_en     <= 1'b0;
            r_cmd_done    <= 1'b0;
            r_write_addr  <= '0;
            r_write_len   <= '0;
        end else begin
            r_cmd_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (cmd_start_i) begin
                        r_cur_addr  <= cmd_addr_i & c_ADDR_MASK;
                        r_rem_beats <= cmd_beats_i;
                        r_cmd_done  <= (cmd_beats_i == '0);
                    end
                end
                c_ST_CALC: begin
                    r_burst_beats <= w_burst;
                    r_write_addr  <= r_cur_addr;
                    r_write_len   <= 8'(w_burst - 9'd1);
                end
                c_ST_WAIT_DONE: begin
                    if (w_burst_end) begin
                        r_cur_addr  <= w_addr_next;
                        r_rem_beats <= w_rem_next;
                        r_cmd_done  <= (w_rem_next == '0);
                    end
                end
                default: ;
            endcase

            // The beat gate opens at ISSUE and closes right after the tlast handshake.
            if (r_state == c_ST_ISSUE) begin
                r_data_en  <= 1'b1;
                r_beat_cnt <= '0;
            end else if (w_fire) begin
                r_beat_cnt <= r_beat_cnt + 9'd1;
                if (w_last) begin
                    r_data_en <= 1'b0;
                end
            end
        end
    end

    assign cmd_busy_o    = (r_state != c_ST_IDLE);
    assign cmd_done_o    = r_cmd_done;
    assign write_start_o = (r_state == c_ST_ISSUE);
    assign write_addr_o  = r_write_addr;
    assign write_len_o   = r_write_len;
    assign write_size_o  = 3'(c_SIZE_LOG);
    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tvalid = s_axis_tvalid && r_data_en;
    assign s_axis_tready = m_axis_tready && r_data_en;
    assign m_axis_tlast  = w_last;

endmodule
`default_nettype wire

// File: tb/tb_s2mm_burst_splitter.sv
`default_nettype none
// ============================================================================
// Module   : tb_s2mm_burst_splitter
// Brief    : Directed/randomized bench for s2mm_burst_splitter with a
//            page/burst-rule reference model and a write-channel responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_s2mm_burst_splitter;

    localparam int DW = 64;
    localparam int AW = 32;
    localparam int BW = 24;

    logic          m_axi_aclk = 1'b0;
    logic          m_axi_areset;
    logic          cmd_start_i;
    logic [AW-1:0] cmd_addr_i;
    logic [BW-1:0] cmd_beats_i;
    logic          cmd_busy_o;
    logic          cmd_done_o;
    logic          write_start_o;
    logic [AW-1:0] write_addr_o;
    logic [7:0]    write_len_o;
    logic [2:0]    write_size_o;
    logic          write_busy_i = 1'b0;
    logic [DW-1:0] s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tready = 1'b0;

    always #5 m_axi_aclk = ~m_axi_aclk;

    s2mm_burst_splitter #(
        .DMA_DATA_WIDTH_SRC(DW),
        .DMA_AXI_ADDR_WIDTH(AW),
        .CMD_BEATS_WIDTH   (BW)
    ) dut (
        .m_axi_aclk   (m_axi_aclk),
        .m_axi_areset (m_axi_areset),
        .cmd_start_i  (cmd_start_i),
        .cmd_addr_i   (cmd_addr_i),
        .cmd_beats_i  (cmd_beats_i),
        .cmd_busy_o   (cmd_busy_o),
        .cmd_done_o   (cmd_done_o),
        .write_start_o(write_start_o),
        .write_addr_o (write_addr_o),
        .write_len_o  (write_len_o),
        .write_size_o (write_size_o),
        .write_busy_i (write_busy_i),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tready(m_axis_tready)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Traffic shaping knobs, set by the main sequence.
    int valid_pct = 100;
    int ready_pct = 100;
    int busy_max  = 0;

    // Observations collected by the bus-functional process.
    int          src_cnt = 0;
    int          sink_cnt = 0;
    int          data_err = 0;
    int          leak_cnt = 0;
    int          beats_in_burst = 0;
    int          fall_cyc = 0;
    bit          in_gap = 1'b1;
    bit          src_fire = 1'b0;
    bit          wc_req = 1'b0;
    bit          wc_tl = 1'b0;
    int          wc_up = 0;
    int          wc_dn = 0;
    logic [31:0] ws_addr_q[$];
    int          ws_len_q[$];
    int          ws_size_q[$];
    int          ws_cyc_q[$];
    int          blen_q[$];
    int          done_q[$];

    // Beat n of the whole run always carries this value.
    function automatic logic [63:0] gen(input int n);
        return {32'(n) * 32'h9E3779B9, 32'(n) ^ 32'hC3A5_0F1E};
    endfunction

    // Drive at the falling edge, then sample what the next rising edge will see.
    always @(negedge m_axi_aclk) begin
        cyc++;
        if (src_fire || cyc == 1) s_axis_tdata = gen(src_cnt);
        if (m_axi_areset) begin
            write_busy_i   = 1'b0;
            wc_req         = 1'b0;
            wc_tl          = 1'b0;
            in_gap         = 1'b1;
            beats_in_burst = 0;
            s_axis_tvalid  = 1'b0;
            m_axis_tready  = 1'b0;
        end else begin
            if (!s_axis_tvalid || src_fire)
                s_axis_tvalid = ($urandom_range(0, 99) < valid_pct);
            m_axis_tready = ($urandom_range(0, 99) < ready_pct);
            if (wc_req && !write_busy_i) begin
                if (wc_up == 0) begin
                    write_busy_i = 1'b1;
                    wc_req       = 1'b0;
                end else wc_up--;
            end else if (write_busy_i && wc_tl) begin
                if (wc_dn == 0) begin
                    write_busy_i = 1'b0;
                    wc_tl        = 1'b0;
                    fall_cyc     = cyc;
                end else wc_dn--;
            end
        end
        #1;
        src_fire = s_axis_tvalid && s_axis_tready;
        if (src_fire) src_cnt++;
        if (m_axis_tvalid && m_axis_tready) begin
            if (in_gap) leak_cnt++;
            if (m_axis_tdata !== gen(sink_cnt)) data_err++;
            sink_cnt++;
            beats_in_burst++;
            if (m_axis_tlast) begin
                blen_q.push_back(beats_in_burst);
                beats_in_burst = 0;
                in_gap = 1'b1;
                wc_tl  = 1'b1;
                wc_dn  = $urandom_range(0, busy_max);
            end
        end
        if (write_start_o) begin
            ws_addr_q.push_back(write_addr_o);
            ws_len_q.push_back(int'(write_len_o));
            ws_size_q.push_back(int'(write_size_o));
            ws_cyc_q.push_back(cyc);
            in_gap = 1'b0;
            wc_req = 1'b1;
            wc_tl  = 1'b0;
            wc_up  = $urandom_range(0, busy_max);
        end
        if (cmd_done_o) done_q.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge m_axi_aclk);
        #2;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".busy"},     64'(cmd_busy_o), 0);
        chk({tag, ".done"},     64'(cmd_done_o), 0);
        chk({tag, ".wstart"},   64'(write_start_o), 0);
        chk({tag, ".s_tready"}, 64'(s_axis_tready), 0);
        chk({tag, ".m_tvalid"}, 64'(m_axis_tvalid), 0);
        chk({tag, ".m_tlast"},  64'(m_axis_tlast), 0);
        chk({tag, ".waddr"},    64'(write_addr_o), 0);
        chk({tag, ".wlen"},     64'(write_len_o), 0);
    endtask

    // Pulse cmd_start_i for exactly one cycle; t0 is the cycle it is sampled in.
    task automatic issue(input logic [31:0] addr, input int beats, output int t0);
        step();
        cmd_addr_i  = addr;
        cmd_beats_i = BW'(beats);
        cmd_start_i = 1'b1;
        t0 = cyc;
        step();
        cmd_start_i = 1'b0;
    endtask

    task automatic run_cmd(input string name, input logic [31:0] addr, input int beats,
                           input int pulse_at);
        logic [31:0] e_addr[$];
        int          e_len[$];
        logic [31:0] a;
        int rem, n, to4k, t0, nb, ne;
        int nb0 = ws_addr_q.size();
        int nl0 = blen_q.size();
        int nd0 = done_q.size();
        int no0 = sink_cnt;
        int de0 = data_err;
        int lk0 = leak_cnt;
        bit timed_out = 1'b1;

        a   = addr & ~32'h7;
        rem = beats;
        while (rem > 0) begin
            to4k = (4096 - int'(a[11:0])) / 8;
            n    = (rem < 256) ? rem : 256;
            if (n > to4k) n = to4k;
            e_addr.push_back(a);
            e_len.push_back(n - 1);
            a   = a + 32'(n * 8);
            rem = rem - n;
        end

        issue(addr, beats, t0);
        if (beats == 0) begin
            chk({name, ".done_T1"},     64'(cmd_done_o), 1);
            chk({name, ".busy_T1"},     64'(cmd_busy_o), 0);
            chk({name, ".s_tready_T1"}, 64'(s_axis_tready), 0);
        end else begin
            chk({name, ".busy_T1"}, 64'(cmd_busy_o), 1);
            chk({name, ".done_T1"}, 64'(cmd_done_o), 0);
        end

        for (int k = 0; k < 20000; k++) begin
            if (done_q.size() > nd0) begin
                timed_out = 1'b0;
                break;
            end
            step();
            if (cmd_start_i) cmd_start_i = 1'b0;
            if (pulse_at > 0 && cyc == t0 + pulse_at) begin
                cmd_addr_i  = 32'h0000_5000;
                cmd_beats_i = BW'(7);
                cmd_start_i = 1'b1;
            end
        end
        cmd_start_i = 1'b0;
        chk({name, ".timeout"}, 64'(timed_out), 0);
        chk({name, ".busy_at_done"}, 64'(cmd_busy_o), 0);

        nb = ws_addr_q.size() - nb0;
        ne = e_addr.size();
        chk({name, ".bursts"}, 64'(nb), 64'(ne));
        for (int i = 0; i < ne && i < nb; i++) begin
            chk($sformatf("%s.b%0d.addr", name, i), 64'(ws_addr_q[nb0+i]), 64'(e_addr[i]));
            chk($sformatf("%s.b%0d.len", name, i),  64'(ws_len_q[nb0+i]),  64'(e_len[i]));
            chk($sformatf("%s.b%0d.size", name, i), 64'(ws_size_q[nb0+i]), 3);
            if (nl0 + i < blen_q.size())
                chk($sformatf("%s.b%0d.beats", name, i), 64'(blen_q[nl0+i]), 64'(e_len[i] + 1));
        end
        chk({name, ".tlast_count"}, 64'(blen_q.size() - nl0), 64'(ne));
        chk({name, ".beats_out"},   64'(sink_cnt - no0), 64'(beats));
        chk({name, ".data_err"},    64'(data_err - de0), 0);
        chk({name, ".leaks"},       64'(leak_cnt - lk0), 0);
        chk({name, ".src_sink"},    64'(src_cnt), 64'(sink_cnt));
        if (beats > 0 && nb > 0 && !timed_out) begin
            chk({name, ".first_start_cyc"}, 64'(ws_cyc_q[nb0]), 64'(t0 + 2));
            chk({name, ".done_after_fall"}, 64'(done_q[nd0] > fall_cyc), 1);
        end
        if (beats == 0 && !timed_out)
            chk({name, ".done_cyc"}, 64'(done_q[nd0]), 64'(t0 + 1));

        repeat (10) step();
        chk({name, ".extra_starts"}, 64'(ws_addr_q.size() - nb0), 64'(ne));
        chk({name, ".single_done"},  64'(done_q.size() - nd0), 1);
        chk({name, ".idle_busy"},    64'(cmd_busy_o), 0);
    endtask

    initial begin
        int t0, nd0, no0;
        bit reached;

        m_axi_areset = 1'b1;
        cmd_start_i  = 1'b0;
        cmd_addr_i   = '0;
        cmd_beats_i  = '0;
        repeat (3) step();
        chk_all_zero("reset");
        chk("reset.size", 64'(write_size_o), 3);
        m_axi_areset = 1'b0;
        step();

        valid_pct = 100; ready_pct = 100; busy_max = 1;
        run_cmd("aligned16", 32'h0000_1000, 16, 0);

        valid_pct = 75; ready_pct = 70; busy_max = 3;
        run_cmd("long600", 32'h0000_0000, 600, 0);

        valid_pct = 90; ready_pct = 60; busy_max = 2;
        run_cmd("cross4k", 32'h0000_0FC0, 20, 0);

        run_cmd("zero", 32'h0000_3000, 0, 0);

        valid_pct = 50; ready_pct = 55; busy_max = 4;
        run_cmd("stall300", 32'h0000_3F00, 300, 40);

        // Abandon a 16-beat burst after its fifth beat.
        valid_pct = 100; ready_pct = 100; busy_max = 2;
        nd0 = done_q.size();
        no0 = sink_cnt;
        reached = 1'b0;
        issue(32'h0000_4000, 16, t0);
        for (int k = 0; k < 200; k++) begin
            if (sink_cnt - no0 >= 5) begin
                reached = 1'b1;
                break;
            end
            step();
        end
        chk("midrst.reached_beat5", 64'(reached), 1);
        m_axi_areset = 1'b1;
        step();
        chk_all_zero("midrst");
        m_axi_areset = 1'b0;
        repeat (5) step();
        chk("midrst.no_done", 64'(done_q.size() - nd0), 0);
        chk("midrst.idle", 64'(cmd_busy_o), 0);
        run_cmd("after_rst", 32'h0000_2000, 4, 0);

        for (int r = 0; r < 3; r++) begin
            valid_pct = $urandom_range(30, 100);
            ready_pct = $urandom_range(30, 100);
            busy_max  = $urandom_range(0, 5);
            run_cmd($sformatf("rand%0d", r), $urandom, $urandom_range(1, 400), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/s2mm_burst_splitter.md
Name: s2mm_burst_splitter

Overview:
Upstream command/stream stage for the S2MM write channel. Accepts one transfer command (start address, total beat count) and an untimed AXI-Stream without tlast. Splits the transfer into AXI4 INCR bursts of at most 256 beats that never cross a 4 KB boundary. For each burst it drives the write channel's write_start/addr/len/size command and forwards exactly that burst's beats with tlast on the final beat.

Parameters:
DMA_DATA_WIDTH_SRC, 64, stream/AXI data width in bits; power of two, 32..1024.
DMA_AXI_ADDR_WIDTH, 32, AXI address width.
CMD_BEATS_WIDTH, 24, width of the total-beat-count field.

Ports:
m_axi_aclk  in  1  clock.
m_axi_areset  in  1  synchronous active-high reset.
cmd_start_i  in  1  command strobe; sampled only in IDLE.
cmd_addr_i  in  DMA_AXI_ADDR_WIDTH  transfer start byte address; low SIZE_LOG bits forced to 0.
cmd_beats_i  in  CMD_BEATS_WIDTH  total beats to write.
cmd_busy_o  out  1  transfer in progress.
cmd_done_o  out  1  one-cycle pulse when the transfer completes.
write_start_o  out  1  burst command strobe to the write channel.
write_addr_o  out  DMA_AXI_ADDR_WIDTH  burst start address.
write_len_o  out  8  AXI awlen (beats-1).
write_size_o  out  3  AXI awsize, constant SIZE_LOG = log2(DMA_DATA_WIDTH_SRC/8).
write_busy_i  in  1  write channel busy.
s_axis_tdata  in  DMA_DATA_WIDTH_SRC  input stream data.
s_axis_tvalid  in  1  input valid.
s_axis_tready  out  1  input ready.
m_axis_tdata  out  DMA_DATA_WIDTH_SRC  stream data to the write channel.
m_axis_tvalid  out  1  output valid.
m_axis_tlast  out  1  last beat of the current burst.
m_axis_tready  in  1  output ready.

Behaviour:
- Reset: all state, outputs, counters to 0; FSM to IDLE. cmd_busy_o, cmd_done_o, write_start_o, s_axis_tready, m_axis_tvalid and m_axis_tlast are all 0. Reset mid-transfer abandons the transfer; no cmd_done_o pulse is generated.
- Registers: rem_beats (CMD_BEATS_WIDTH), cur_addr, burst_beats (9 bits), beat_cnt (9 bits), data_en.
- IDLE: cmd_start_i=1 in cycle T captures the aligned address and cmd_beats_i.
  - If cmd_beats_i=0: cmd_done_o pulses in T+1; no burst is issued; cmd_busy_o stays 0.
  - Otherwise go to CALC; cmd_busy_o=1 from T+1.
- cmd_start_i outside IDLE is ignored.
- CALC (1 cycle):
  - to_4k = (4096 - cur_addr[11:0]) >> SIZE_LOG.
  - burst_beats = min(rem_beats, 256, to_4k).
  - write_addr_o = cur_addr; write_len_o = burst_beats-1. Both are held stable until the next CALC.
  - Go to ISSUE.
- ISSUE (1 cycle): write_start_o=1 only here (first ISSUE at T+2). Sets data_en=1 and beat_cnt=0. Go to WAIT_ACCEPT.
- WAIT_ACCEPT: wait for write_busy_i=1, then go to WAIT_DONE. write_start_o stays 0, giving the write channel a clean rising edge per burst.
- WAIT_DONE: wait for write_busy_i=0 and data_en=0.
  - Then: cur_addr += burst_beats<<SIZE_LOG; rem_beats -= burst_beats.
  - If the result is 0: go to IDLE, pulse cmd_done_o, drop cmd_busy_o in the same cycle.
  - Else go to CALC.
- Data path is combinational pass-through, gated by data_en:
  - m_axis_tdata = s_axis_tdata.
  - m_axis_tvalid = s_axis_tvalid & data_en.
  - s_axis_tready = m_axis_tready & data_en.
  - m_axis_tlast = data_en & (beat_cnt == burst_beats-1).
- Each m_axis handshake increments beat_cnt. A handshake with tlast clears data_en next cycle, so no beat of the following burst leaks before its ISSUE.
- Data may be accepted from the cycle after ISSUE, independent of write_busy_i. Arbitrary stall patterns on either side never drop or duplicate beats.
- Address arithmetic wraps modulo 2^DMA_AXI_ADDR_WIDTH.
- A transfer larger than memory top is not checked.

Test Plan:
- Aligned single burst: addr 0x1000, 16 beats, 64-bit data.
  -> One write_start_o pulse at T+2 with addr 0x1000, len 15, size 3.
  -> tlast on beat 16; cmd_done_o after write_busy_i falls.
- Long transfer: addr 0x0, 600 beats.
  -> Bursts (addr,len): (0x0,255), (0x800,255), (0x1000,87).
  -> Exactly one tlast per burst; 600 beats total out.
- 4 KB crossing: addr 0x0FC0, 20 beats.
  -> Bursts (0x0FC0,7), (0x1000,11).
- Zero beats: cmd_beats_i=0.
  -> cmd_done_o at T+1; write_start_o never asserts; s_axis_tready stays 0.
- Backpressure and ignored start:
  - Random tvalid/tready toggling over a 300-beat command; cmd_start_i pulsed mid-transfer.
  -> Output data matches input order.
  -> Second command ignored.
  -> No beat passes between a tlast and the next write_start_o.
- Reset mid-burst: assert m_axi_areset after beat 5 of a 16-beat burst.
  -> Next cycle all outputs 0, FSM in IDLE, no cmd_done_o.
  -> A following 4-beat command at 0x2000 completes normally.
